// File: rtl/snd_cmd_queue.sv
// Main-CPU to sound-CPU command path: legacy change-detect latch (mode 0)
// or a DEPTH-entry command FIFO with NMI pending/ack and overflow (mode 1).
module snd_cmd_queue #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       clk_sys,
    input  logic                       reset,
    input  logic                       mode,
    input  logic                       wr_cen,
    input  logic                       wr,
    input  logic [DATA_W-1:0]          wdata,
    input  logic                       rd_cen,
    input  logic                       rd,
    input  logic                       nmi_ack,
    input  logic                       clr_ovf,
    output logic [DATA_W-1:0]          rdata,
    output logic                       nmi,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW-1:0]     wptr, wptr_nx;
    logic [AW-1:0]     rptr, rptr_nx;
    logic [CW-1:0]     cnt, cnt_nx;
    logic [DATA_W-1:0] hold, hold_nx;
    logic [DATA_W-1:0] last, last_nx;
    logic              nmi_q, nmi_nx;
    logic              ack_q, ack_nx;
    logic              ovf_q, ovf_nx;
    logic              mode_q;

    logic push, pop, ack;
    logic mode_chg, is_empty, is_full;
    logic push_ok, pop_ok, ovf_set, legacy_push;

    // Qualified events and acceptance decisions
    always_comb begin
        push        = wr & wr_cen;
        pop         = rd & rd_cen;
        ack         = nmi_ack & rd_cen;
        mode_chg    = mode ^ mode_q;
        is_empty    = (cnt == '0);
        is_full     = (cnt == CW'(DEPTH));
        // full implies non-empty, so a pop alongside frees the slot the push needs
        push_ok     = mode & push & (~is_full | pop) & ~mode_chg;
        pop_ok      = mode & pop & ~is_empty & ~mode_chg;
        ovf_set     = mode & push & is_full & ~pop & ~mode_chg;
        legacy_push = ~mode & push & ~mode_chg;
    end

    // Next-state logic
    always_comb begin
        wptr_nx = wptr;
        rptr_nx = rptr;
        cnt_nx  = cnt;
        hold_nx = hold;
        last_nx = last;
        nmi_nx  = nmi_q;
        ack_nx  = 1'b0;
        ovf_nx  = ovf_q;

        if (clr_ovf && wr_cen) ovf_nx = 1'b0;
        if (ovf_set)           ovf_nx = 1'b1;

        if (mode_chg) begin
            wptr_nx = '0;
            rptr_nx = '0;
            cnt_nx  = '0;
            nmi_nx  = 1'b0;
        end else if (!mode) begin
            if (ack) nmi_nx = 1'b0;
            if (legacy_push) begin
                hold_nx = wdata;
                cnt_nx  = CW'(1);
                if (wdata != hold) nmi_nx = 1'b1;
            end
        end else begin
            if (push_ok) wptr_nx = wptr + AW'(1);
            if (pop_ok) begin
                rptr_nx = rptr + AW'(1);
                last_nx = mem[rptr];
            end
            cnt_nx = cnt + CW'(push_ok) - CW'(pop_ok);
            // ack forces one low cycle; re-arm happens the cycle after
            if (ack) begin
                nmi_nx = 1'b0;
                ack_nx = 1'b1;
            end else if (push_ok || (ack_q && !is_empty)) begin
                nmi_nx = 1'b1;
            end
        end
    end

    // State registers
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wptr   <= '0;
            rptr   <= '0;
            cnt    <= '0;
            hold   <= '0;
            last   <= '0;
            nmi_q  <= 1'b0;
            ack_q  <= 1'b0;
            ovf_q  <= 1'b0;
            mode_q <= 1'b0;
        end else begin
            wptr   <= wptr_nx;
            rptr   <= rptr_nx;
            cnt    <= cnt_nx;
            hold   <= hold_nx;
            last   <= last_nx;
            nmi_q  <= nmi_nx;
            ack_q  <= ack_nx;
            ovf_q  <= ovf_nx;
            mode_q <= mode;
        end
    end

    // Storage is don't-care after reset; pointers decide what is valid
    always_ff @(posedge clk_sys) begin
        if (push_ok) mem[wptr] <= wdata;
    end

    always_comb begin
        if (mode) rdata = is_empty ? last : mem[rptr];
        else      rdata = hold;
        nmi      = nmi_q;
        count    = cnt;
        empty    = is_empty;
        full     = is_full;
        overflow = ovf_q;
    end

endmodule

// File: tb/tb_snd_cmd_queue.sv
// Directed bench for snd_cmd_queue with a FIFO scoreboard and immediate assertions.
module tb_snd_cmd_queue;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic       mode;
    logic       wr_cen, wr, rd_cen, rd, nmi_ack, clr_ovf;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       nmi, empty, full, overflow;
    logic [2:0] count;

    int checks = 0;
    int errors = 0;
    int mcount = 0;
    logic [7:0] sb[$];
    logic [7:0] exp_v;

    snd_cmd_queue #(.DATA_W(8), .DEPTH(4)) dut (
        .clk_sys(clk_sys), .reset(reset), .mode(mode),
        .wr_cen(wr_cen), .wr(wr), .wdata(wdata),
        .rd_cen(rd_cen), .rd(rd), .nmi_ack(nmi_ack), .clr_ovf(clr_ovf),
        .rdata(rdata), .nmi(nmi), .count(count),
        .empty(empty), .full(full), .overflow(overflow)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    // FIFO-mode push with model update
    task automatic do_push(input logic [7:0] v);
        if (mcount < 4) begin
            sb.push_back(v);
            mcount++;
        end
        wr = 1'b1; wdata = v;
        step();
        wr = 1'b0;
        chk("push_count", 32'(count), 32'(mcount));
        chk("push_nmi", 32'(nmi), 32'(1));
    endtask

    task automatic do_pop();
        exp_v = sb.pop_front();
        mcount--;
        chk("pop_head", 32'(rdata), 32'(exp_v));
        rd = 1'b1;
        step();
        rd = 1'b0;
        chk("pop_count", 32'(count), 32'(mcount));
    endtask

    initial begin
        reset = 1'b1; mode = 1'b0; wr_cen = 1'b1; rd_cen = 1'b1;
        wr = 1'b0; rd = 1'b0; nmi_ack = 1'b0; clr_ovf = 1'b0; wdata = 8'h00;
        step(); step();
        chk("rst_count", 32'(count), 32'(0));
        chk("rst_empty", 32'(empty), 32'(1));
        chk("rst_full", 32'(full), 32'(0));
        chk("rst_nmi", 32'(nmi), 32'(0));
        chk("rst_ovf", 32'(overflow), 32'(0));
        chk("rst_rdata", 32'(rdata), 32'(0));
        reset = 1'b0;
        step();

        // Legacy latch
        wr = 1'b1; wdata = 8'h12; step(); wr = 1'b0;
        chk("m0_nmi_set", 32'(nmi), 32'(1));
        chk("m0_rdata", 32'(rdata), 32'(8'h12));
        chk("m0_count", 32'(count), 32'(1));
        nmi_ack = 1'b1; step(); nmi_ack = 1'b0;
        chk("m0_ack", 32'(nmi), 32'(0));
        wr = 1'b1; wdata = 8'h12; step(); wr = 1'b0;
        chk("m0_equal_push", 32'(nmi), 32'(0));
        chk("m0_rdata2", 32'(rdata), 32'(8'h12));
        wr = 1'b1; wr_cen = 1'b0; wdata = 8'h55; step(); wr = 1'b0; wr_cen = 1'b1;
        chk("m0_cen_gate", 32'(rdata), 32'(8'h12));
        chk("m0_cen_nmi", 32'(nmi), 32'(0));

        // Switch to FIFO
        mode = 1'b1; step();
        chk("m1_flush_count", 32'(count), 32'(0));
        chk("m1_flush_empty", 32'(empty), 32'(1));

        do_push(8'hA1); do_push(8'hA2); do_push(8'hA3); do_push(8'hA4);
        chk("fill_full", 32'(full), 32'(1));
        chk("fill_ovf_clear", 32'(overflow), 32'(0));
        do_push(8'hA5);
        chk("ovf_set", 32'(overflow), 32'(1));
        chk("ovf_full", 32'(full), 32'(1));
        for (int i = 0; i < 4; i++) do_pop();
        chk("drain_empty", 32'(empty), 32'(1));
        chk("drain_last", 32'(rdata), 32'(8'hA4));
        step();
        chk("drain_last2", 32'(rdata), 32'(8'hA4));
        clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
        chk("ovf_clr", 32'(overflow), 32'(0));

        // Push + pop while full
        do_push(8'hC0); do_push(8'hC1); do_push(8'hC2); do_push(8'hC3);
        exp_v = sb.pop_front();
        chk("fp_head", 32'(rdata), 32'(exp_v));
        sb.push_back(8'hB0);
        wr = 1'b1; wdata = 8'hB0; rd = 1'b1; step(); wr = 1'b0; rd = 1'b0;
        chk("fp_count", 32'(count), 32'(4));
        chk("fp_ovf", 32'(overflow), 32'(0));
        chk("fp_newhead", 32'(rdata), 32'(8'hC1));
        for (int i = 0; i < 4; i++) do_pop();
        chk("fp_last_b0", 32'(rdata), 32'(8'hB0));

        // NMI ack behaviour
        nmi_ack = 1'b1; step(); nmi_ack = 1'b0;
        chk("ack_empty_low", 32'(nmi), 32'(0));
        step();
        chk("ack_empty_stay", 32'(nmi), 32'(0));
        do_push(8'hD0); do_push(8'hD1);
        nmi_ack = 1'b1; step(); nmi_ack = 1'b0;
        chk("ack_low_cycle", 32'(nmi), 32'(0));
        step();
        chk("ack_rearm", 32'(nmi), 32'(1));
        step();
        chk("ack_rearm_hold", 32'(nmi), 32'(1));
        do_pop(); do_pop();
        nmi_ack = 1'b1; step(); nmi_ack = 1'b0;
        chk("ack_final_low", 32'(nmi), 32'(0));
        step(); step();
        chk("ack_final_stay", 32'(nmi), 32'(0));

        // Pointer wrap with up to 3 outstanding
        do_push(8'd0); do_push(8'd1); do_push(8'd2);
        for (int i = 3; i < 10; i++) begin
            exp_v = sb.pop_front();
            chk("wrap_head", 32'(rdata), 32'(exp_v));
            sb.push_back(8'(i));
            wr = 1'b1; wdata = 8'(i); rd = 1'b1; step(); wr = 1'b0; rd = 1'b0;
            chk("wrap_count", 32'(count), 32'(3));
        end
        do_pop(); do_pop(); do_pop();
        chk("wrap_empty", 32'(empty), 32'(1));

        // Flush on mode toggle
        do_push(8'hE0); do_push(8'hE1); do_push(8'hE2);
        mode = 1'b0; step();
        sb.delete(); mcount = 0;
        chk("flush_count", 32'(count), 32'(0));
        chk("flush_nmi", 32'(nmi), 32'(0));
        chk("flush_empty", 32'(empty), 32'(1));
        chk("flush_hold", 32'(rdata), 32'(8'h12));

        // Asynchronous reset in the middle of a push
        wr = 1'b1; wdata = 8'h77; step();
        chk("pre_rst_nmi", 32'(nmi), 32'(1));
        chk("pre_rst_rdata", 32'(rdata), 32'(8'h77));
        wdata = 8'h88;
        #2 reset = 1'b1;
        #1;
        chk("arst_rdata", 32'(rdata), 32'(0));
        chk("arst_nmi", 32'(nmi), 32'(0));
        chk("arst_count", 32'(count), 32'(0));
        chk("arst_empty", 32'(empty), 32'(1));
        chk("arst_full", 32'(full), 32'(0));
        chk("arst_ovf", 32'(overflow), 32'(0));
        wr = 1'b0;
        step();
        reset = 1'b0;
        step();
        chk("post_rst_count", 32'(count), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/snd_cmd_queue.md
Name: snd_cmd_queue

Overview:
- Parametrised successor to the single-byte main-CPU to sound-CPU command latch with its change-detect NMI.
- Runs in one clock domain (clk_sys). Each CPU side is qualified by its own clock enable.
- Mode 0 reproduces the legacy behaviour: one register, NMI raised when the written value differs from the held value.
- Mode 1 is a DEPTH-entry FIFO with NMI pending, NMI ack, occupancy reporting and a sticky overflow flag, so back-to-back commands are no longer lost.

Parameters:
- DATA_W, 8, command width in bits.
- DEPTH, 4, FIFO entries; must be a power of 2 and at least 2.
- AW, log2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- mode  in  1  0 = legacy latch, 1 = FIFO.
- wr_cen  in  1  main-CPU-side clock enable.
- wr  in  1  write strobe; qualified by wr_cen.
- wdata  in  DATA_W  command byte.
- rd_cen  in  1  sound-CPU-side clock enable.
- rd  in  1  pop strobe; qualified by rd_cen.
- nmi_ack  in  1  NMI acknowledge; qualified by rd_cen.
- clr_ovf  in  1  clears overflow; qualified by wr_cen.
- rdata  out  DATA_W  current command seen by the sound CPU.
- nmi  out  1  active-high NMI request to the sound CPU.
- count  out  AW+1  number of stored entries.
- empty  out  1  asserted when count==0.
- full  out  1  asserted when count==DEPTH.
- overflow  out  1  sticky: a write was dropped.

Behaviour:
- Reset (asynchronous, active-high) values:
  - Pointers and count = 0.
  - rdata holding register = 0.
  - nmi = 0, overflow = 0, empty = 1, full = 0.
  - Memory contents are don't-care.
- Event definitions:
  - push: wr & wr_cen.
  - pop: rd & rd_cen.
  - ack: nmi_ack & rd_cen.
- Mode 0 (legacy):
  - On push, the hold register takes wdata.
  - If wdata differs from the previously held value, nmi is set at the next edge. An equal value does not set nmi.
  - ack clears nmi. If push-with-change and ack occur in the same cycle, set wins.
  - rdata = hold register, combinationally.
  - Pops are ignored. count = 1 after the first push, else 0. full = 0. overflow never sets.
- Mode 1 (FIFO):
  - Push when not full: write mem[wptr], increment wptr (wraps modulo DEPTH), set nmi pending.
  - Push when full, with no pop in the same cycle: data is dropped, overflow is set, pointers are unchanged.
  - Push and pop in the same cycle while full: both are accepted, count is unchanged, overflow stays clear.
  - Pop when not empty: the last register takes mem[rptr], rptr increments (wraps).
  - Pop when empty: ignored, no state change.
  - Push and pop in the same cycle while empty: push accepted, pop ignored.
  - rdata = empty ? last : mem[rptr], combinational. The sound CPU reads the head, then pops.
  - nmi pending is cleared by ack.
  - If the FIFO is non-empty after the ack cycle, nmi re-asserts on the following cycle. This guarantees at least one low cycle per ack so that edge-triggered NMI re-fires.
  - Push and ack in the same cycle: ack takes effect first, then the push re-arms nmi; the low cycle is still guaranteed.
- count: updated by +1, -1 or 0 per cycle. full and empty are derived combinationally from count.
- overflow: cleared by clr_ovf. If clr_ovf and an overflow event occur in the same cycle, set wins.
- Mode change: any change of mode, detected against a registered copy, flushes the block at the next edge:
  - Pointers, count and nmi = 0.
  - Hold register and last are retained.
  - Pushes and pops in the flush cycle are discarded.
- Reset mid-operation: immediate return to reset values. No partial write is committed.
- Latency:
  - push to nmi: 1 cycle.
  - push to rdata (when empty): 1 cycle.
  - pop to next head on rdata: 1 cycle.

Test Plan:
- Mode 0: push 0x12, then push 0x12 again. Required: nmi=1 one cycle after the first push; after ack, the second (equal) push leaves nmi=0; rdata=0x12 throughout.
- Mode 1, DEPTH=4: push 0xA1, 0xA2, 0xA3, 0xA4, 0xA5. Required: full=1 and count=4 after the 4th push; the 5th push sets overflow=1 and is dropped; pops return A1..A4 in order; empty=1 afterwards; rdata=0xA4 (last) on further reads.
- Mode 1, full: push 0xB0 together with a pop in the same cycle. Required: count stays 4, overflow=0, head advances, 0xB0 is popped last.
- Mode 1: two queued entries, ack with no pop. Required: nmi low for exactly one cycle, then high again. After popping both entries and a further ack: nmi stays 0.
- Mode 1, pointer wrap: 10 push/pop pairs with values 0..9 and at most 3 entries outstanding. Required: data order is preserved across the wptr/rptr wrap and count never exceeds 3.
- Flush and reset: with 3 entries queued, toggle mode. Required: next cycle count=0, nmi=0, empty=1. Then assert reset mid-push. Required: all outputs return to reset values asynchronously, with no edge needed.
